// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the pipelined RV32I core.
// Build option: define FETCH_NOP_BUBBLE_EN to make bubbles carry addi x0,x0,0 instead of zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [1:0]  dbg_state
);

`ifdef FETCH_NOP_BUBBLE_EN
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

  // Handshake: a request transfers on a cycle where ImemReq && ImemGnt; ImemReq may
  // drop without a grant (stall or redirect). Exactly one request is outstanding, and
  // its response is the next ImemRValid pulse seen in S_WAIT (no back-pressure on it).
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pcf, pcf_n;
  logic [31:0] reqpc, reqpc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic        kill, kill_n;
  logic        deliver;
  logic [31:0] dlv_instr;
  logic [31:0] dlv_pc;

  assign ImemAddr  = pcf;
  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    pcf_n        = pcf;
    reqpc_n      = reqpc;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    kill_n       = kill;
    deliver      = 1'b0;
    dlv_instr    = ImemRData;
    dlv_pc       = reqpc;
    ImemReq      = 1'b0;

    case (state)
      S_REQ: begin
        ImemReq = !StallF && !PCSrcE;
        if (ImemReq && ImemGnt) begin
          reqpc_n = pcf;
          pcf_n   = pcf + 32'd4;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ImemRValid) begin
          if (kill || PCSrcE) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else if (!StallD) begin
            deliver = 1'b1;
            state_n = S_REQ;
          end else begin
            hold_instr_n = ImemRData;
            hold_pc_n    = reqpc;
            state_n      = S_HOLD;
          end
        end else if (PCSrcE) begin
          // Response is still in flight; remember to throw it away.
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE || FlushD) begin
          state_n = S_REQ;
        end else if (!StallD) begin
          deliver   = 1'b1;
          dlv_instr = hold_instr;
          dlv_pc    = hold_pc;
          state_n   = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    // A redirect overrides any grant increment and ignores StallF.
    if (PCSrcE) pcf_n = PCTargetE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pcf        <= RESET_PC;
      reqpc      <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
      kill       <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      reqpc      <= reqpc_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      kill       <= kill_n;
    end
  end

  // IF/ID register: flush beats stall, stall beats a delivery, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= BUBBLE;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (deliver) begin
      InstrD   <= dlv_instr;
      PCD      <= dlv_pc;
      PCPlus4D <= dlv_pc + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= BUBBLE;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level memory/control stimulus, expected deliveries
// queued at issue time and checked by an independent IF/ID monitor.
module tb_fetch_stage;

`ifdef FETCH_NOP_BUBBLE_EN
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic        ImemGnt = 0, ImemRValid = 0;
  logic [31:0] ImemRData = 0;
  logic        ImemReq, ValidD;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  logic [1:0]  dbg_state;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemGnt(ImemGnt), .ImemRValid(ImemRValid), .ImemRData(ImemRData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [95:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_pc;
  logic        sd_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) sd_e <= StallD;

  always @(negedge clk) begin
    if (sd_e === 1'b0) begin
      if (ValidD) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'h0, ValidD}, 32'h0);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          chk("instr", InstrD, e[95:64]);
          chk("pcd", PCD, e[63:32]);
          chk("pcplus4d", PCPlus4D, e[31:0]);
        end
      end else begin
        chk("bubble_instr", InstrD, BUBBLE);
        chk("bubble_pcd", PCD, 32'h0);
        chk("bubble_pc4", PCPlus4D, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  // One fetch: optional StallF cycles (maybe with a redirect), grant delay, response
  // latency with optional redirect while waiting, then the response cycle with optional
  // redirect/flush/StallD, and optional HOLD release with a drop.
  task automatic txn(input int sf, input bit redir_sf, input logic [31:0] tgt_sf,
                     input int gdly, input int lat, input int kill_at,
                     input logic [31:0] tgt_k, input bit redir_resp,
                     input logic [31:0] tgt_r, input bit flush_resp, input int stall_n,
                     input int hold_drop, input logic [31:0] tgt_h);
    logic [31:0] a;
    logic [31:0] held;
    bit killed;
    for (int i = 0; i < sf; i++) begin
      StallF = 1; PCSrcE = redir_sf && (i == sf - 1); PCTargetE = tgt_sf;
      ImemGnt = 1'($urandom_range(0, 1)); ImemRValid = 1'($urandom_range(0, 1));
      ImemRData = $urandom;
      #1;
      chk("req_stallf", {31'h0, ImemReq}, 32'h0);
      chk("addr_stallf", ImemAddr, model_pc);
      step();
      if (redir_sf && (i == sf - 1)) model_pc = tgt_sf;
    end
    StallF = 0; PCSrcE = 0;
    for (int i = 0; i <= gdly; i++) begin
      ImemGnt = (i == gdly); ImemRValid = 1'($urandom_range(0, 1)); ImemRData = $urandom;
      #1;
      chk("req_issue", {31'h0, ImemReq}, 32'h1);
      chk("addr_issue", ImemAddr, model_pc);
      step();
    end
    a = model_pc;
    model_pc = a + 32'd4;
    ImemGnt = 0; ImemRValid = 0;
    killed = 0;
    for (int i = 1; i < lat; i++) begin
      PCSrcE = (i == kill_at); PCTargetE = tgt_k;
      #1;
      chk("req_wait", {31'h0, ImemReq}, 32'h0);
      step();
      if (i == kill_at) begin killed = 1; model_pc = tgt_k; end
    end
    held = InstrD;
    ImemRValid = 1; ImemRData = mem_word(a);
    PCSrcE = redir_resp; PCTargetE = tgt_r; FlushD = flush_resp; StallD = (stall_n > 0);
    if (!killed && !redir_resp && stall_n == 0 && !flush_resp)
      exp_q.push_back({mem_word(a), a, a + 32'd4});
    step();
    if (redir_resp) model_pc = tgt_r;
    ImemRValid = 0; ImemRData = $urandom; PCSrcE = 0; FlushD = 0;
    if (!killed && !redir_resp && stall_n > 0) begin
      if (flush_resp) held = BUBBLE;
      for (int i = 1; i < stall_n; i++) begin
        chk("hold_instr", InstrD, held);
        chk("req_hold", {31'h0, ImemReq}, 32'h0);
        step();
      end
      chk("hold_instr", InstrD, held);
      chk("req_hold", {31'h0, ImemReq}, 32'h0);
      StallD = 0; FlushD = (hold_drop == 1); PCSrcE = (hold_drop == 2); PCTargetE = tgt_h;
      if (hold_drop == 0) exp_q.push_back({mem_word(a), a, a + 32'd4});
      step();
      if (hold_drop == 2) model_pc = tgt_h;
      FlushD = 0; PCSrcE = 0;
    end
    StallD = 0;
  endtask

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    model_pc = RST_PC;
    repeat (3) step();
    rst = 0;
    #1;
    chk("rst_valid", {31'h0, ValidD}, 32'h0);
    chk("rst_instr", InstrD, BUBBLE);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_req", {31'h0, ImemReq}, 32'h1);
    chk("rst_addr", ImemAddr, RST_PC);

    // Basic fetch at RESET_PC, one-cycle memory.
    txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_valid", {31'h0, ValidD}, 32'h1);
    chk("t1_instr", InstrD, 32'h0050_0093);
    chk("t1_pcd", PCD, 32'h100);
    chk("t1_pc4", PCPlus4D, 32'h104);
    chk("t1_next_addr", ImemAddr, 32'h104);
    chk("t1_next_req", {31'h0, ImemReq}, 32'h1);

    // StallD for 3 cycles across the response.
    txn(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 3, 0, 0);

    // Redirect while waiting on a slow response.
    txn(0, 0, 0, 0, 4, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("kill_valid", {31'h0, ValidD}, 32'h0);
    chk("kill_addr", ImemAddr, 32'h200);

    // Flush wins over stall.
    txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    StallF = 1; StallD = 1; FlushD = 1;
    step();
    chk("flush_valid", {31'h0, ValidD}, 32'h0);
    chk("flush_instr", InstrD, BUBBLE);
    StallF = 0; StallD = 0; FlushD = 0;

    // StallF for 2 cycles with a redirect to the top of memory, then wrap.
    txn(2, 1, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_addr", ImemAddr, 32'h0);

    // Reset in the middle of a transaction; a stale response is ignored.
    ImemGnt = 1;
    step();
    ImemGnt = 0; rst = 1;
    step();
    rst = 0; ImemRValid = 1; ImemRData = 32'hDEAD_BEEF;
    #1;
    chk("mid_rst_req", {31'h0, ImemReq}, 32'h1);
    chk("mid_rst_addr", ImemAddr, RST_PC);
    step();
    ImemRValid = 0;
    model_pc = RST_PC;

    // Random mix.
    for (int n = 0; n < 80; n++) begin
      int lat;
      int stall_n;
      lat = $urandom_range(1, 4);
      stall_n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), rand_tgt(),
          $urandom_range(0, 2), lat,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : 0, rand_tgt(),
          ($urandom_range(0, 5) == 0), rand_tgt(),
          ($urandom_range(0, 5) == 0), stall_n,
          $urandom_range(0, 4) < 3 ? 0 : $urandom_range(1, 2), rand_tgt());
    end

    repeat (3) step();
    chk("drain", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
